pool_result_fifo: RTL and testbench

//   Output stage directly downstream of the dual-kernel conv/ReLU/pool pipeline.

---
 rtl/pool_result_fifo.sv | 88 ++++++++
 tb/tb_pool_result_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pool_result_fifo.sv
// rtl/pool_result_fifo.sv - first-word fall-through FIFO for paired pooled results with frame tagging
// Overflow drops incoming samples (the pipeline cannot stall); sticky error flags are cleared by err_clr.
module pool_result_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          valid_in_bus,
    input  logic [2*DATA_W-1:0] din_bus,
    input  logic [CNT_W-1:0]    frame_len,
    input  logic                err_clr,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [2*DATA_W-1:0] out_data,
    output logic                out_last,
    output logic [ADDR_W:0]     fifo_level,
    output logic                overflow,
    output logic                mismatch
);
    localparam int              ENT_W    = 2*DATA_W + 1;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic [CNT_W-1:0]  cnt;
    logic [ENT_W-1:0]  head;

    logic push_req;
    logic pop;
    logic push_ok;
    logic drop;
    logic mism_evt;
    logic last_bit;

    assign push_req = (valid_in_bus == 2'b11);
    assign mism_evt = (valid_in_bus == 2'b01) || (valid_in_bus == 2'b10);
    assign pop      = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign push_ok  = push_req && ((level != FULL_LVL) || pop);
    assign drop     = push_req && !push_ok;
    assign last_bit = (frame_len != '0) && (cnt == frame_len - CNT_W'(1));

    assign head       = mem[rd_ptr];
    assign out_valid  = (level != '0);
    assign out_data   = out_valid ? head[2*DATA_W-1:0] : '0;
    assign out_last   = out_valid ? head[ENT_W-1] : 1'b0;
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {last_bit, din_bus};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // Dropped samples still advance the counter to keep frame alignment.
            if (push_req) begin
                cnt <= last_bit ? '0 : cnt + 1'b1;
            end
            overflow <= (overflow && !err_clr) || drop;
            mismatch <= (mismatch && !err_clr) || mism_evt;
        end
    end
endmodule

// File: tb/tb_pool_result_fifo.sv
// tb/tb_pool_result_fifo.sv - self-checking bench for pool_result_fifo
// Table vectors, directed corner sequences and random traffic against a queue-based model.
module tb_pool_result_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  valid_in_bus = 2'b00;
    logic [31:0] din_bus = '0;
    logic [15:0] frame_len = '0;
    logic        err_clr = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        mismatch;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mcnt;
    logic        m_ov;
    logic        m_mm;

    typedef struct {
        logic [1:0]  vin;
        logic [31:0] din;
        logic        clr;
        logic        ready;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic [4:0]  elev;
        logic        eov;
        logic        emm;
    } vec_t;

    vec_t tbl[8];

    pool_result_fifo dut (
        .clk(clk), .rst(rst), .valid_in_bus(valid_in_bus), .din_bus(din_bus),
        .frame_len(frame_len), .err_clr(err_clr), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .fifo_level(fifo_level), .overflow(overflow), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] dut_pack();
        return {24'd0, out_valid, out_last, overflow, mismatch, 3'd0, fifo_level, out_data};
    endfunction

    function automatic logic [63:0] model_pack();
        logic        v = (mq.size() != 0);
        logic [31:0] d = v ? mq[0].data : 32'd0;
        logic        l = v ? mq[0].last : 1'b0;
        logic [4:0]  lv = 5'(mq.size());
        return {24'd0, v, l, m_ov, m_mm, 3'd0, lv, d};
    endfunction

    task automatic model_reset();
        mq.delete();
        mcnt = '0;
        m_ov = 1'b0;
        m_mm = 1'b0;
    endtask

    // One clock: drive inputs, advance the model by the rules, compare after the edge.
    task automatic step(input logic [1:0] vin, input logic [31:0] din,
                        input logic clr, input logic rdy, input string name);
        bit   popped;
        bit   is_last;
        bit   drop;
        ent_t e;
        valid_in_bus = vin;
        din_bus      = din;
        err_clr      = clr;
        out_ready    = rdy;
        @(posedge clk);
        popped = (mq.size() != 0) && rdy;
        drop   = 1'b0;
        if (popped) void'(mq.pop_front());
        if (vin == 2'b11) begin
            is_last = (frame_len != 0) && (mcnt == frame_len - 16'd1);
            if (mq.size() < DEPTH) begin
                e.last = is_last;
                e.data = din;
                mq.push_back(e);
            end else begin
                drop = 1'b1;
            end
            mcnt = is_last ? 16'd0 : mcnt + 16'd1;
        end
        m_ov = (m_ov && !clr) || drop;
        m_mm = (m_mm && !clr) || (vin == 2'b01) || (vin == 2'b10);
        #1;
        chk(name, dut_pack(), model_pack());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_in_bus = 2'b00;
        err_clr = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("reset_state", dut_pack(), 64'd0);
    endtask

    initial begin
        model_reset();
        tbl[0] = '{2'b11, 32'h0005_FFFE, 0, 1, 1, 32'h0005_FFFE, 0, 5'd1, 0, 0};
        tbl[1] = '{2'b11, 32'h0007_0000, 0, 1, 1, 32'h0007_0000, 0, 5'd1, 0, 0};
        tbl[2] = '{2'b11, 32'h0001_0001, 0, 1, 1, 32'h0001_0001, 0, 5'd1, 0, 0};
        tbl[3] = '{2'b00, 32'h0000_0000, 0, 1, 0, 32'h0000_0000, 0, 5'd0, 0, 0};
        tbl[4] = '{2'b01, 32'h1234_5678, 0, 1, 0, 32'h0000_0000, 0, 5'd0, 0, 1};
        tbl[5] = '{2'b00, 32'h0000_0000, 1, 1, 0, 32'h0000_0000, 0, 5'd0, 0, 0};
        tbl[6] = '{2'b10, 32'h0000_0000, 1, 1, 0, 32'h0000_0000, 0, 5'd0, 0, 1};
        tbl[7] = '{2'b00, 32'h0000_0000, 1, 1, 0, 32'h0000_0000, 0, 5'd0, 0, 0};

        @(posedge clk);
        #1;
        do_reset();

        frame_len = 16'd0;
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].vin, tbl[i].din, tbl[i].clr, tbl[i].ready, "table_model");
            chk($sformatf("table_row%0d", i), dut_pack(),
                {24'd0, tbl[i].ev, tbl[i].el, tbl[i].eov, tbl[i].emm, 3'd0, tbl[i].elev, tbl[i].ed});
        end

        // Frame of 4, consumer always ready: last on samples 4 and 8.
        do_reset();
        frame_len = 16'd4;
        for (int i = 0; i < 8; i++) begin
            step(2'b11, 32'h00A0_0000 + 32'(i), 0, 1, "frame4_model");
            chk($sformatf("frame4_last%0d", i), {63'd0, out_last}, {63'd0, (i == 3 || i == 7)});
        end
        step(2'b00, 0, 0, 1, "frame4_drain");

        // Overflow with stalled consumer; dropped samples still counted for framing.
        do_reset();
        frame_len = 16'd6;
        for (int i = 0; i < 18; i++) step(2'b11, 32'(i), 0, 0, "ovf_fill");
        chk("ovf_level", {59'd0, fifo_level}, 64'd16);
        chk("ovf_flag", {63'd0, overflow}, 64'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_head%0d", i), {31'd0, out_last, out_data},
                {31'd0, (i == 5 || i == 11), 32'(i)});
            step(2'b00, 0, 0, 1, "ovf_drain");
        end
        chk("ovf_empty", {59'd0, fifo_level}, 64'd0);

        // Push and pop together while full.
        do_reset();
        frame_len = 16'd0;
        for (int i = 0; i < 16; i++) step(2'b11, 32'hBEEF_0000 + 32'(i), 0, 0, "full_fill");
        step(2'b11, 32'hCAFE_0001, 0, 1, "full_pushpop");
        chk("full_level", {59'd0, fifo_level}, 64'd16);
        chk("full_no_ovf", {63'd0, overflow}, 64'd0);
        chk("full_head", {32'd0, out_data}, 64'hBEEF_0001);

        // Asynchronous reset mid-frame.
        do_reset();
        frame_len = 16'd4;
        for (int i = 0; i < 5; i++) step(2'b11, 32'h7000_0000 + 32'(i), 0, 0, "rst_fill");
        chk("rst_pre_level", {59'd0, fifo_level}, 64'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", {58'd0, out_valid, fifo_level}, 64'd0);
        @(posedge clk);
        #1;
        chk("rst_next", {58'd0, out_valid, fifo_level}, 64'd0);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 32'h8000_0000 + 32'(i), 0, 1, "rst_frame_model");
            chk($sformatf("rst_frame_last%0d", i), {63'd0, out_last}, {63'd0, (i == 3)});
        end

        // Random traffic against the model.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            frame_len = (r == 0) ? 16'($urandom_range(1, 7)) : 16'd0;
            for (int i = 0; i < 400; i++) begin
                int unsigned p = $urandom_range(0, 9);
                logic [1:0]  v = (p < 7) ? 2'b11 : (p == 7) ? 2'b00 : (p == 8) ? 2'b01 : 2'b10;
                logic        rd = ((i % 64) < 24) ? 1'b0 : ($urandom_range(0, 3) != 0);
                logic        c = ($urandom_range(0, 15) == 0);
                step(v, $urandom, c, rd, "random_model");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
